// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and RAM status encoding.
// No logic; types only.
// Used by the memory arbiter and its bench.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// Memory arbiter state and grant encodings plus streak counter sizing.
// No logic; types and a sizing helper only.
// Imported by mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2,
        FAULT = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_grant_t;

    // Streak counter must hold DSTREAK_MAX and is never narrower than 3 bits.
    function automatic int streak_width(input int max_streak);
        int w;
        w = $clog2(max_streak + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts access-state cycles, cleared on every grant.
// tmo is combinational and high in the access cycle whose count edge reaches TIMEOUT.
// No backpressure; the arbiter leaves the access state when tmo fires.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tmo
);

    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // Cycle counter: cleared by reset or a new grant, advanced while an access is open.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    // The edge that would bring the count to TIMEOUT is the one that faults.
    assign tmo = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one RAM port; data wins, bounded by a fetch anti-starvation streak.
// Latency: request seen in IDLE -> strobes next cycle -> hit one cycle after RAM ACCESS (minimum 2 cycles).
// Requesters hold their request until the hit pulse; RAM stalls via ramstate BUSY, watchdog bounds the stall.
module mem_arbiter
    import cpu_types_pkg::*;
    import mem_arb_pkg::*;
#(
    parameter int DSTREAK_MAX = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      ihit,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dhit,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    localparam int SW = streak_width(DSTREAK_MAX);

    arb_state_t    state_q, state_d;
    word_t         addr_q, addr_d;
    word_t         store_q, store_d;
    logic          wr_q, wr_d;
    logic          abort_q, abort_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          ihit_q, ihit_d;
    logic          dhit_q, dhit_d;
    word_t         iload_q, iload_d;
    word_t         dload_q, dload_d;
    logic          err_q, err_d;

    logic          dreq, ireq, in_acc, own_req, gnt_vld, wd_tmo;
    arb_grant_t    gnt;

    // A requester completing this cycle is still holding its request; mask it.
    assign dreq   = (dREN || dWEN) && !dhit_q;
    assign ireq   = iREN && !ihit_q;
    assign in_acc = (state_q == I_ACC) || (state_q == D_ACC);

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk (CLK),
        .rst (RST),
        .clr (gnt_vld),
        .en  (in_acc),
        .tmo (wd_tmo)
    );

    // State register and all datapath registers; reset abandons any open access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            abort_q  <= 1'b0;
            streak_q <= '0;
            ihit_q   <= 1'b0;
            dhit_q   <= 1'b0;
            iload_q  <= '0;
            dload_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
            abort_q  <= abort_d;
            streak_q <= streak_d;
            ihit_q   <= ihit_d;
            dhit_q   <= dhit_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
            err_q    <= err_d;
        end
    end

    // Arbitration, access completion and fault detection.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wr_d     = wr_q;
        abort_d  = abort_q;
        streak_d = streak_q;
        ihit_d   = 1'b0;
        dhit_d   = 1'b0;
        iload_d  = iload_q;
        dload_d  = dload_q;
        err_d    = err_q;
        gnt_vld  = 1'b0;
        gnt      = GNT_I;
        own_req  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dreq && (!ireq || (streak_q < SW'(DSTREAK_MAX)))) begin
                    gnt_vld = 1'b1;
                    gnt     = GNT_D;
                end else if (ireq) begin
                    gnt_vld = 1'b1;
                    gnt     = GNT_I;
                end

                if (gnt_vld) begin
                    store_d = dstore;
                    abort_d = 1'b0;
                    if (gnt == GNT_D) begin
                        addr_d  = daddr;
                        wr_d    = dWEN;
                        state_d = D_ACC;
                        // Only data wins taken over a waiting fetch count toward the limit.
                        if (ireq) begin
                            streak_d = (streak_q == '1) ? streak_q : streak_q + SW'(1);
                        end else begin
                            streak_d = '0;
                        end
                    end else begin
                        addr_d   = iaddr;
                        wr_d     = 1'b0;
                        state_d  = I_ACC;
                        streak_d = '0;
                    end
                end
            end

            I_ACC, D_ACC: begin
                // A dropped request still lets the RAM finish; only the hit is withheld.
                own_req = (state_q == I_ACC) ? iREN : (dREN || dWEN);
                abort_d = abort_q || !own_req;
                if (ramstate == ERROR) begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                end else if (ramstate == ACCESS) begin
                    state_d = IDLE;
                    if (state_q == I_ACC) begin
                        iload_d = ramload;
                        ihit_d  = !abort_d;
                    end else begin
                        dload_d = ramload;
                        dhit_d  = !abort_d;
                    end
                end else if (wd_tmo) begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                end
            end

            FAULT: begin
                state_d = FAULT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ramREN   = (state_q == I_ACC) || ((state_q == D_ACC) && !wr_q);
    assign ramWEN   = (state_q == D_ACC) && wr_q;
    assign ramaddr  = in_acc ? addr_q  : '0;
    assign ramstore = in_acc ? store_q : '0;
    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus directed streak and timeout sequences.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// All RAM stalls are driven directly through ramstate.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    word_t     iload, dload, ramaddr, ramstore;
    logic      ihit, dhit, ramREN, ramWEN, err;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.DSTREAK_MAX(4), .TIMEOUT(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .ihit     (ihit),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dhit     (dhit),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic      rst, iren, dren, dwen;
        word_t     ia, da, ds;
        ramstate_t rs;
        word_t     rl;
        logic      e_ren, e_wen;
        word_t     e_addr, e_store;
        logic      e_ihit, e_dhit, e_err;
        word_t     e_iload, e_dload;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(
        input logic rst, input logic iren, input logic dren, input logic dwen,
        input word_t ia, input word_t da, input word_t ds,
        input ramstate_t rs, input word_t rl,
        input logic e_ren, input logic e_wen, input word_t e_addr, input word_t e_store,
        input logic e_ihit, input logic e_dhit, input logic e_err,
        input word_t e_iload, input word_t e_dload);
        vec_t v;
        v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen;
        v.ia = ia; v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_store = e_store;
        v.e_ihit = e_ihit; v.e_dhit = e_dhit; v.e_err = e_err;
        v.e_iload = e_iload; v.e_dload = e_dload;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Expected grant order under a permanently waiting fetch: 1 = data, 0 = fetch.
    logic stv_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        // rst iren dren dwen | ia da ds | rs rl | ren wen addr store | ihit dhit err | iload dload
        // Reset state, then single fetch with ACCESS on the 3rd access cycle
        tbl.push_back(mkv(0,0,0,0, 0,0,0, FREE,0,   0,0,0,0, 0,0,0, 0,0));
        tbl.push_back(mkv(0,1,0,0, 32'h40,0,0, FREE,0,   0,0,0,0, 0,0,0, 0,0));
        tbl.push_back(mkv(0,1,0,0, 32'h40,0,0, BUSY,0,   1,0,32'h40,0, 0,0,0, 0,0));
        tbl.push_back(mkv(0,1,0,0, 32'h40,0,0, BUSY,0,   1,0,32'h40,0, 0,0,0, 0,0));
        tbl.push_back(mkv(0,1,0,0, 32'h40,0,0, ACCESS,32'h8C220004, 1,0,32'h40,0, 0,0,0, 0,0));
        tbl.push_back(mkv(0,1,0,0, 32'h40,0,0, FREE,0,   0,0,0,0, 1,0,0, 32'h8C220004,0));
        tbl.push_back(mkv(0,0,0,0, 0,0,0, FREE,0,   0,0,0,0, 0,0,0, 32'h8C220004,0));
        // Simultaneous fetch and write: data first, fetch granted in the dhit cycle
        tbl.push_back(mkv(0,1,0,1, 32'h44,32'h100,32'hDEADBEEF, FREE,0, 0,0,0,0, 0,0,0, 32'h8C220004,0));
        tbl.push_back(mkv(0,1,0,1, 32'h44,32'h100,32'hDEADBEEF, ACCESS,32'h11111111, 0,1,32'h100,32'hDEADBEEF, 0,0,0, 32'h8C220004,0));
        tbl.push_back(mkv(0,1,0,1, 32'h44,32'h100,32'hDEADBEEF, FREE,0, 0,0,0,0, 0,1,0, 32'h8C220004,32'h11111111));
        tbl.push_back(mkv(0,1,0,0, 32'h44,0,0, ACCESS,32'h22222222, 1,0,32'h44,0, 0,0,0, 32'h8C220004,32'h11111111));
        tbl.push_back(mkv(0,1,0,0, 32'h44,0,0, FREE,0, 0,0,0,0, 1,0,0, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(0,0,0,0, 0,0,0, FREE,0, 0,0,0,0, 0,0,0, 32'h22222222,32'h11111111));
        // Aborted write: strobe held to ACCESS, no dhit
        tbl.push_back(mkv(0,0,0,1, 0,32'h200,32'hCAFEF00D, FREE,0, 0,0,0,0, 0,0,0, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(0,0,0,0, 0,0,0, BUSY,0, 0,1,32'h200,32'hCAFEF00D, 0,0,0, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(0,0,0,0, 0,0,0, ACCESS,32'h11111111, 0,1,32'h200,32'hCAFEF00D, 0,0,0, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(0,0,0,0, 0,0,0, FREE,0, 0,0,0,0, 0,0,0, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(0,0,0,0, 0,0,0, FREE,0, 0,0,0,0, 0,0,0, 32'h22222222,32'h11111111));
        // RAM ERROR during fetch: sticky err, requests ignored until reset
        tbl.push_back(mkv(0,1,0,0, 32'h80,0,0, FREE,0, 0,0,0,0, 0,0,0, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(0,1,0,0, 32'h80,0,0, ERROR,0, 1,0,32'h80,0, 0,0,0, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(0,1,1,0, 32'h80,32'h300,0, FREE,0, 0,0,0,0, 0,0,1, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(0,1,1,0, 32'h80,32'h300,0, ACCESS,32'h44444444, 0,0,0,0, 0,0,1, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(0,1,1,0, 32'h80,32'h300,0, FREE,0, 0,0,0,0, 0,0,1, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(1,0,0,0, 0,0,0, FREE,0, 0,0,0,0, 0,0,1, 32'h22222222,32'h11111111));
        tbl.push_back(mkv(0,1,0,0, 32'h84,0,0, FREE,0, 0,0,0,0, 0,0,0, 0,0));
        tbl.push_back(mkv(0,1,0,0, 32'h84,0,0, ACCESS,32'h33333333, 1,0,32'h84,0, 0,0,0, 0,0));
        tbl.push_back(mkv(0,1,0,0, 32'h84,0,0, FREE,0, 0,0,0,0, 1,0,0, 32'h33333333,0));
        tbl.push_back(mkv(0,0,0,0, 0,0,0, FREE,0, 0,0,0,0, 0,0,0, 32'h33333333,0));
        // Reset in the middle of an access: strobe drops, no hit
        tbl.push_back(mkv(0,1,0,0, 32'h88,0,0, FREE,0, 0,0,0,0, 0,0,0, 32'h33333333,0));
        tbl.push_back(mkv(1,1,0,0, 32'h88,0,0, BUSY,0, 1,0,32'h88,0, 0,0,0, 32'h33333333,0));
        tbl.push_back(mkv(0,0,0,0, 0,0,0, ACCESS,32'h55555555, 0,0,0,0, 0,0,0, 0,0));
        tbl.push_back(mkv(0,0,0,0, 0,0,0, FREE,0, 0,0,0,0, 0,0,0, 0,0));

        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        step();
        step();

        foreach (tbl[i]) begin
            RST = tbl[i].rst; iREN = tbl[i].iren; dREN = tbl[i].dren; dWEN = tbl[i].dwen;
            iaddr = tbl[i].ia; daddr = tbl[i].da; dstore = tbl[i].ds;
            ramstate = tbl[i].rs; ramload = tbl[i].rl;
            chk($sformatf("r%0d ramREN", i),  ramREN,  tbl[i].e_ren);
            chk($sformatf("r%0d ramWEN", i),  ramWEN,  tbl[i].e_wen);
            chk($sformatf("r%0d ramaddr", i), ramaddr, tbl[i].e_addr);
            if (tbl[i].e_wen)
                chk($sformatf("r%0d ramstore", i), ramstore, tbl[i].e_store);
            chk($sformatf("r%0d ihit", i),  ihit,  tbl[i].e_ihit);
            chk($sformatf("r%0d dhit", i),  dhit,  tbl[i].e_dhit);
            chk($sformatf("r%0d err", i),   err,   tbl[i].e_err);
            chk($sformatf("r%0d iload", i), iload, tbl[i].e_iload);
            chk($sformatf("r%0d dload", i), dload, tbl[i].e_dload);
            step();
        end
        RST = 1'b0;

        // Streak bound: both requests raised together each round; fetch drops in the hit cycle
        daddr = 32'h300; iaddr = 32'h400; dstore = '0;
        for (int k = 0; k < 10; k++) begin
            iREN = 1'b1; dREN = 1'b1; ramstate = FREE;
            step();
            chk($sformatf("stv%0d ramREN", k), ramREN, 1'b1);
            chk($sformatf("stv%0d grant addr", k), ramaddr, stv_d[k] ? 32'h300 : 32'h400);
            ramstate = ACCESS; ramload = 32'(k);
            step();
            chk($sformatf("stv%0d dhit", k), dhit, stv_d[k]);
            chk($sformatf("stv%0d ihit", k), ihit, !stv_d[k]);
            iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
            step();
        end

        // Watchdog: RAM stuck BUSY, err rises 9 cycles after the grant cycle
        iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
        for (int c = 1; c <= 9; c++) begin
            step();
            chk($sformatf("tmo c%0d err", c), err, 32'(c == 9));
        end
        chk("tmo ramREN", ramREN, 1'b0);
        iREN = 1'b0; ramstate = FREE; RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        chk("tmo reset err", err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
